// File: rtl/rk4_step_sequencer.sv
// rk4_step_sequencer
//   Drives one shared evaluator (dy/dx = (X+H-Y-K)/2) through the four RK4 stages of every step.
//   Each step forms y_next = y + h/6*(k1+2k2+2k3+k4) and x_next = x + h, and the step repeats
//   n_steps times. All values are signed fixed point with FRAC fractional bits.
//
//   Optional feature: define RK4_SAT_EN to saturate eval_k and the x_out/y_out updates to the
//   signed n-bit range. When RK4_SAT_EN is undefined, results wrap (two's complement truncation).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                run request, accepted only while busy=0
//   x0, y0, h, n_steps   run operands, latched on accept
//   busy, done           run in progress / one-cycle finish pulse
//   eval_x/y/h/k         evaluator operands (current x, current y, x offset, y offset)
//   eval_dydx            evaluator result
//   x_out, y_out         current/final x and y
//   step_cnt             steps completed in this run
module rk4_step_sequencer #(
  parameter int unsigned n        = 32,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned EVAL_LAT = 0,
  parameter int unsigned SW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [n-1:0]  x0,
  input  logic [n-1:0]  y0,
  input  logic [n-1:0]  h,
  input  logic [SW-1:0] n_steps,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  eval_x,
  output logic [n-1:0]  eval_y,
  output logic [n-1:0]  eval_h,
  output logic [n-1:0]  eval_k,
  input  logic [n-1:0]  eval_dydx,
  output logic [n-1:0]  x_out,
  output logic [n-1:0]  y_out,
  output logic [SW-1:0] step_cnt
);

  // Internal working width: wide enough that h*s and the following 1/6 scaling never overflow.
  localparam int unsigned DW = 3 * n + 8;
  localparam int unsigned WW = (EVAL_LAT > 0) ? $clog2(EVAL_LAT + 1) : 1;
  localparam logic [WW-1:0] LastWait = WW'(EVAL_LAT);
  localparam logic signed [DW-1:0] OneSixth = DW'(((64'd1 << FRAC) + 64'd3) / 64'd6);

  typedef enum logic [2:0] {
    StIdle,
    StK1,
    StK2,
    StK3,
    StK4,
    StUpd
  } state_e;

  // Sign-extend an n-bit value to the working width.
  function automatic logic signed [DW-1:0] sx(input logic [n-1:0] v);
    return DW'($signed(v));
  endfunction

  // Reduce a working-width result to n bits (clamp or wrap depending on the build).
  function automatic logic [n-1:0] fit(input logic signed [DW-1:0] v);
`ifdef RK4_SAT_EN
    logic signed [DW-1:0] max_v;
    logic signed [DW-1:0] min_v;
    max_v = sx({1'b0, {(n-1){1'b1}}});
    min_v = sx({1'b1, {(n-1){1'b0}}});
    if (v > max_v) begin
      return {1'b0, {(n-1){1'b1}}};
    end else if (v < min_v) begin
      return {1'b1, {(n-1){1'b0}}};
    end else begin
      return v[n-1:0];
    end
`else
    return v[n-1:0];
`endif
  endfunction

  // Full-precision signed product followed by an arithmetic right shift.
  function automatic logic signed [DW-1:0] mul_shr(input logic [n-1:0] a,
                                                    input logic [n-1:0] b,
                                                    input int unsigned  sh);
    logic signed [DW-1:0] p;
    p = sx(a) * sx(b);
    return p >>> sh;
  endfunction

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [n-1:0]  h_q, h_d;
  logic [SW-1:0] n_steps_q, n_steps_d;
  logic [n-1:0]  k1_q, k1_d, k2_q, k2_d, k3_q, k3_d, k4_q, k4_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [n-1:0]  x_out_q, x_out_d, y_out_q, y_out_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [n-1:0]  eval_x_q, eval_x_d, eval_y_q, eval_y_d;
  logic [n-1:0]  eval_h_q, eval_h_d, eval_k_q, eval_k_d;

  logic                 stage_last;
  logic signed [DW-1:0] s_sum;
  logic signed [DW-1:0] hs_prod;
  logic signed [DW-1:0] y_delta;
  logic [n-1:0]         x_next;
  logic [n-1:0]         y_next;
  logic [n-1:0]         h_half;
  logic                 last_step;

  // Step update datapath, only consumed in StUpd.
  always_comb begin
    s_sum     = sx(k1_q) + (sx(k2_q) <<< 1) + (sx(k3_q) <<< 1) + sx(k4_q);
    hs_prod   = (sx(h_q) * s_sum) >>> FRAC;
    y_delta   = (hs_prod * OneSixth) >>> FRAC;
    x_next    = fit(sx(x_out_q) + sx(h_q));
    y_next    = fit(sx(y_out_q) + y_delta);
    h_half    = $signed(h_q) >>> 1;
    // step_cnt_q < n_steps_q throughout a run, so the increment cannot wrap here.
    last_step = ((step_cnt_q + SW'(1)) == n_steps_q);
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    h_d        = h_q;
    n_steps_d  = n_steps_q;
    k1_d       = k1_q;
    k2_d       = k2_q;
    k3_d       = k3_q;
    k4_d       = k4_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    step_cnt_d = step_cnt_q;
    eval_x_d   = eval_x_q;
    eval_y_d   = eval_y_q;
    eval_h_d   = eval_h_q;
    eval_k_d   = eval_k_q;
    stage_last = (wait_q == LastWait);

    // Evaluator operands are held for EVAL_LAT+1 cycles in every stage.
    if (state_q inside {StK1, StK2, StK3, StK4}) begin
      wait_d = stage_last ? '0 : wait_q + WW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          h_d        = h;
          n_steps_d  = n_steps;
          x_out_d    = x0;
          y_out_d    = y0;
          step_cnt_d = '0;
          wait_d     = '0;
          if (n_steps == '0) begin
            // Empty run: finish immediately, evaluator untouched.
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            busy_d   = 1'b1;
            state_d  = StK1;
            eval_x_d = x0;
            eval_y_d = y0;
            eval_h_d = '0;
            eval_k_d = '0;
          end
        end
      end
      StK1: begin
        if (stage_last) begin
          k1_d     = eval_dydx;
          eval_h_d = h_half;
          eval_k_d = fit(mul_shr(h_q, eval_dydx, FRAC + 1));
          state_d  = StK2;
        end
      end
      StK2: begin
        if (stage_last) begin
          k2_d     = eval_dydx;
          eval_h_d = h_half;
          eval_k_d = fit(mul_shr(h_q, eval_dydx, FRAC + 1));
          state_d  = StK3;
        end
      end
      StK3: begin
        if (stage_last) begin
          k3_d     = eval_dydx;
          eval_h_d = h_q;
          eval_k_d = fit(mul_shr(h_q, eval_dydx, FRAC));
          state_d  = StK4;
        end
      end
      StK4: begin
        if (stage_last) begin
          k4_d    = eval_dydx;
          state_d = StUpd;
        end
      end
      StUpd: begin
        x_out_d    = x_next;
        y_out_d    = y_next;
        step_cnt_d = step_cnt_q + SW'(1);
        if (last_step) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          eval_x_d = x_next;
          eval_y_d = y_next;
          eval_h_d = '0;
          eval_k_d = '0;
          state_d  = StK1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      h_q        <= '0;
      n_steps_q  <= '0;
      k1_q       <= '0;
      k2_q       <= '0;
      k3_q       <= '0;
      k4_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      step_cnt_q <= '0;
      eval_x_q   <= '0;
      eval_y_q   <= '0;
      eval_h_q   <= '0;
      eval_k_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      h_q        <= h_d;
      n_steps_q  <= n_steps_d;
      k1_q       <= k1_d;
      k2_q       <= k2_d;
      k3_q       <= k3_d;
      k4_q       <= k4_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      step_cnt_q <= step_cnt_d;
      eval_x_q   <= eval_x_d;
      eval_y_q   <= eval_y_d;
      eval_h_q   <= eval_h_d;
      eval_k_q   <= eval_k_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign x_out    = x_out_q;
  assign y_out    = y_out_q;
  assign step_cnt = step_cnt_q;
  assign eval_x   = eval_x_q;
  assign eval_y   = eval_y_q;
  assign eval_h   = eval_h_q;
  assign eval_k   = eval_k_q;

endmodule

// File: tb/tb_rk4_step_sequencer.sv
// Bench for rk4_step_sequencer: a combinational-evaluator instance (EVAL_LAT=0, SW=16) and a
// pipelined-evaluator instance (EVAL_LAT=2, SW=4), both checked against an arithmetic RK4 model.
module tb_rk4_step_sequencer;

  typedef logic signed [127:0] wide_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // Instance with a combinational evaluator
  logic        start;
  logic [31:0] x0, y0, h;
  logic [15:0] n_steps;
  logic        busy, done;
  logic [31:0] ex, ey, eh, ek, edy, x_out, y_out;
  logic [15:0] step_cnt;
  // Instance with a two-cycle evaluator
  logic        start2;
  logic [31:0] x0_2, y0_2, h_2;
  logic [3:0]  n_steps2;
  logic        busy2, done2;
  logic [31:0] ex2, ey2, eh2, ek2, edy2, x_out2, y_out2;
  logic [3:0]  step_cnt2;
  logic [31:0] p1, p2;

  int checks = 0;
  int errors = 0;

  function automatic wide_t sx(input logic [31:0] v);
    return wide_t'($signed(v));
  endfunction

  function automatic logic [31:0] fit(input wide_t v);
`ifdef RK4_SAT_EN
    if (v > 128'sd2147483647) return 32'h7FFFFFFF;
    if (v < -128'sd2147483648) return 32'h80000000;
`endif
    return v[31:0];
  endfunction

  // Golden evaluator: dy/dx = (X + H - Y - K) / 2
  function automatic logic [31:0] golden_f(input logic [31:0] xx, input logic [31:0] yy,
                                           input logic [31:0] hh, input logic [31:0] kk);
    wide_t t;
    t = (sx(xx) + sx(hh) - sx(yy) - sx(kk)) >>> 1;
    return t[31:0];
  endfunction

  // One RK4 step in Q16.16 (n=32, FRAC=16, 1/6 = 10923/65536).
  function automatic void model_step(inout logic [31:0] xx, inout logic [31:0] yy,
                                     input logic [31:0] hh);
    logic [31:0] k1, k2, k3, k4, hh2;
    wide_t t, s, dy;
    t   = sx(hh) >>> 1;
    hh2 = t[31:0];
    k1  = golden_f(xx, yy, 32'd0, 32'd0);
    k2  = golden_f(xx, yy, hh2, fit((sx(hh) * sx(k1)) >>> 17));
    k3  = golden_f(xx, yy, hh2, fit((sx(hh) * sx(k2)) >>> 17));
    k4  = golden_f(xx, yy, hh, fit((sx(hh) * sx(k3)) >>> 16));
    s   = sx(k1) + 2 * sx(k2) + 2 * sx(k3) + sx(k4);
    dy  = (((sx(hh) * s) >>> 16) * 10923) >>> 16;
    yy  = fit(sx(yy) + dy);
    xx  = fit(sx(xx) + sx(hh));
  endfunction

  function automatic void model_run(input logic [31:0] xi, input logic [31:0] yi,
                                    input logic [31:0] hh, input int ns,
                                    output logic [31:0] xf, output logic [31:0] yf);
    xf = xi;
    yf = yi;
    for (int i = 0; i < ns; i++) model_step(xf, yf, hh);
  endfunction

  assign edy = golden_f(ex, ey, eh, ek);
  always @(posedge clk) begin
    p1 <= golden_f(ex2, ey2, eh2, ek2);
    p2 <= p1;
  end
  assign edy2 = p2;

  rk4_step_sequencer #(.n(32), .FRAC(16), .EVAL_LAT(0), .SW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .y0(y0), .h(h), .n_steps(n_steps),
    .busy(busy), .done(done), .eval_x(ex), .eval_y(ey), .eval_h(eh), .eval_k(ek),
    .eval_dydx(edy), .x_out(x_out), .y_out(y_out), .step_cnt(step_cnt)
  );

  rk4_step_sequencer #(.n(32), .FRAC(16), .EVAL_LAT(2), .SW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .x0(x0_2), .y0(y0_2), .h(h_2),
    .n_steps(n_steps2), .busy(busy2), .done(done2), .eval_x(ex2), .eval_y(ey2), .eval_h(eh2),
    .eval_k(ek2), .eval_dydx(edy2), .x_out(x_out2), .y_out(y_out2), .step_cnt(step_cnt2)
  );

  function automatic logic [31:0] rnd_val();
    return 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
  endfunction

  task automatic accept1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [15:0] ns);
    @(negedge clk);
    x0 = a; y0 = b; h = c; n_steps = ns; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic accept2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [3:0] ns);
    @(negedge clk);
    x0_2 = a; y0_2 = b; h_2 = c; n_steps2 = ns; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, step_cnt, x_out, y_out, ex, ey, eh, ek} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b cnt=%0d x=%h y=%h ev=%h/%h/%h/%h want all 0",
               busy, done, step_cnt, x_out, y_out, ex, ey, eh, ek);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_n_zero();
    logic [31:0] a, b;
    a = rnd_val(); b = rnd_val();
    accept1(a, b, 32'h0000_1000, 16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nzero_done: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    checks++;
    if (x_out !== a || y_out !== b || step_cnt !== 16'd0) begin
      errors++;
      $display("FAIL nzero_out: got x=%h y=%h cnt=%0d want x=%h y=%h cnt=0",
               x_out, y_out, step_cnt, a, b);
    end
    checks++;
    if ({ex, ey, eh, ek} !== '0) begin
      errors++;
      $display("FAIL nzero_eval: got %h %h %h %h want all 0", ex, ey, eh, ek);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL nzero_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_one_step();
    logic [31:0] h_tab[4]  = '{32'h0, 32'h4000, 32'h4000, 32'h8000};
    logic [31:0] k_tab[4]  = '{32'h0, 32'hFFFF_E000, 32'hFFFF_EC00, 32'hFFFF_D500};
    logic [31:0] dy_tab[4] = '{32'hFFFF_8000, 32'hFFFF_B000, 32'hFFFF_AA00, 32'hFFFF_D580};
    logic [31:0] xe, ye;
    longint d;
    int c;
    model_run(32'h0, 32'h0001_0000, 32'h0000_8000, 1, xe, ye);
    accept1(32'h0, 32'h0001_0000, 32'h0000_8000, 16'd1);
    c = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (eh !== h_tab[i] || ek !== k_tab[i] || ex !== 32'h0 || ey !== 32'h0001_0000) begin
        errors++;
        $display("FAIL stage%0d_eval: got x=%h y=%h h=%h k=%h want x=0 y=00010000 h=%h k=%h",
                 i + 1, ex, ey, eh, ek, h_tab[i], k_tab[i]);
      end
      d = longint'($signed(edy)) - longint'($signed(dy_tab[i]));
      checks++;
      if (d > 1 || d < -1) begin
        errors++;
        $display("FAIL k%0d_value: got %h want %h +-1", i + 1, edy, dy_tab[i]);
      end
      @(posedge clk); #1; c++;
    end
    while (!done && c < 20) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c + 1 !== 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL one_step_done_cycle: got cycle %0d busy=%b want cycle 6 busy=0", c + 1, busy);
    end
    d = longint'($signed(y_out)) - longint'(32'h0000_D620);
    checks++;
    if (x_out !== 32'h0000_8000 || d > 4 || d < -4 || y_out !== ye || step_cnt !== 16'd1) begin
      errors++;
      $display("FAIL one_step_result: got x=%h y=%h cnt=%0d want x=00008000 y=%h (~0000d620) cnt=1",
               x_out, y_out, step_cnt, ye);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hh, xe, ye;
    int ns, c;
    for (int it = 0; it < 6; it++) begin
      a = rnd_val(); b = rnd_val(); hh = 32'($urandom_range(1, 32'h0002_0000));
      ns = $urandom_range(1, 4);
      model_run(a, b, hh, ns, xe, ye);
      accept1(a, b, hh, 16'(ns));
      c = 0;
      while (!done && c < 40) begin
        @(posedge clk); #1; c++;
      end
      checks++;
      if (c !== ns * 5 || x_out !== xe || y_out !== ye || step_cnt !== 16'(ns) || busy !== 1'b0)
      begin
        errors++;
        $display("FAIL random_run%0d: got edges=%0d x=%h y=%h cnt=%0d want edges=%0d x=%h y=%h cnt=%0d",
                 it, c, x_out, y_out, step_cnt, ns * 5, xe, ye, ns);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, hh, xe, ye, a2, b2, h2, xe2, ye2;
    int c;
    a = rnd_val(); b = rnd_val(); hh = 32'($urandom_range(1, 32'h0001_0000));
    a2 = rnd_val(); b2 = rnd_val(); h2 = 32'($urandom_range(1, 32'h0001_0000));
    model_run(a, b, hh, 3, xe, ye);
    model_run(a2, b2, h2, 1, xe2, ye2);
    @(negedge clk);
    x0 = a; y0 = b; h = hh; n_steps = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    c = 0;
    // Keep start high and scramble the operands on every cycle of the run.
    while (!done && c < 40) begin
      x0 = $urandom; y0 = $urandom; h = $urandom; n_steps = 16'($urandom);
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c !== 15 || step_cnt !== 16'd3 || x_out !== xe || y_out !== ye) begin
      errors++;
      $display("FAIL spam_run: got edges=%0d cnt=%0d x=%h y=%h want edges=15 cnt=3 x=%h y=%h",
               c, step_cnt, x_out, y_out, xe, ye);
    end
    x0 = a2; y0 = b2; h = h2; n_steps = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || step_cnt !== 16'd0 || x_out !== a2) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b cnt=%0d x=%h want busy=1 done=0 cnt=0 x=%h",
               busy, done, step_cnt, x_out, a2);
    end
    c = 0;
    while (!done && c < 20) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c !== 5 || x_out !== xe2 || y_out !== ye2) begin
      errors++;
      $display("FAIL b2b_run: got edges=%0d x=%h y=%h want edges=5 x=%h y=%h",
               c, x_out, y_out, xe2, ye2);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] xe, ye;
    int c;
    accept1(rnd_val(), rnd_val(), 32'h0000_4000, 16'd3);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, step_cnt, x_out, y_out} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b cnt=%0d x=%h y=%h want all 0",
               busy, done, step_cnt, x_out, y_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_run(32'h0, 32'h0001_0000, 32'h0000_8000, 1, xe, ye);
    accept1(32'h0, 32'h0001_0000, 32'h0000_8000, 16'd1);
    c = 0;
    while (!done && c < 20) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c !== 5 || x_out !== xe || y_out !== ye || step_cnt !== 16'd1) begin
      errors++;
      $display("FAIL after_reset_run: got edges=%0d x=%h y=%h cnt=%0d want edges=5 x=%h y=%h cnt=1",
               c, x_out, y_out, step_cnt, xe, ye);
    end
  endtask

  task automatic test_eval_latency();
    logic [31:0] h_tab[4] = '{32'h0, 32'h4000, 32'h4000, 32'h8000};
    logic [127:0] ref_t;
    logic [3:0] unstable;
    logic [31:0] xe, ye;
    int c;
    model_run(32'h0, 32'h0001_0000, 32'h0000_8000, 1, xe, ye);
    accept2(32'h0, 32'h0001_0000, 32'h0000_8000, 4'd1);
    unstable = '0;
    ref_t = '0;
    c = 0;
    for (int j = 0; j < 12; j++) begin
      if (j % 3 == 0) begin
        ref_t = {ex2, ey2, eh2, ek2};
        checks++;
        if (eh2 !== h_tab[j / 3]) begin
          errors++;
          $display("FAIL lat2_stage%0d_h: got %h want %h", j / 3 + 1, eh2, h_tab[j / 3]);
        end
      end else if ({ex2, ey2, eh2, ek2} !== ref_t) begin
        unstable[j / 3] = 1'b1;
      end
      @(posedge clk); #1; c++;
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (unstable[s] !== 1'b0) begin
        errors++;
        $display("FAIL lat2_stage%0d_stable: got changing eval operands want stable", s + 1);
      end
    end
    while (!done2 && c < 30) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c + 1 !== 14 || busy2 !== 1'b0 || x_out2 !== xe || y_out2 !== ye) begin
      errors++;
      $display("FAIL lat2_run: got cycle %0d busy=%b x=%h y=%h want cycle 14 busy=0 x=%h y=%h",
               c + 1, busy2, x_out2, y_out2, xe, ye);
    end
  endtask

  task automatic test_max_steps();
    logic [31:0] a, b, hh, xe, ye;
    int c;
    a = rnd_val(); b = rnd_val(); hh = 32'($urandom_range(1, 32'h0000_4000));
    model_run(a, b, hh, 15, xe, ye);
    accept2(a, b, hh, 4'hF);
    c = 0;
    while (!done2 && c < 220) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c !== 195 || step_cnt2 !== 4'hF || x_out2 !== xe || y_out2 !== ye) begin
      errors++;
      $display("FAIL max_steps: got edges=%0d cnt=%0d x=%h y=%h want edges=195 cnt=15 x=%h y=%h",
               c, step_cnt2, x_out2, y_out2, xe, ye);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] xe, ye;
    int c;
    model_run(32'h7FFF_0000, 32'h7FFF_0000, 32'h0001_0000, 2, xe, ye);
    accept1(32'h7FFF_0000, 32'h7FFF_0000, 32'h0001_0000, 16'd2);
    c = 0;
    while (!done && c < 30) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (c !== 10 || x_out !== xe || y_out !== ye) begin
      errors++;
      $display("FAIL overflow_model: got edges=%0d x=%h y=%h want edges=10 x=%h y=%h",
               c, x_out, y_out, xe, ye);
    end
    checks++;
`ifdef RK4_SAT_EN
    if (x_out !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL overflow_x_clamp: got %h want 7fffffff", x_out);
    end
`else
    if (x_out[31] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_x_wrap: got %h want negative", x_out);
    end
`endif
  endtask

  initial begin
    start = 1'b0; start2 = 1'b0;
    x0 = '0; y0 = '0; h = '0; n_steps = '0;
    x0_2 = '0; y0_2 = '0; h_2 = '0; n_steps2 = '0;
    test_reset();
    test_n_zero();
    test_one_step();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_eval_latency();
    test_max_steps();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
